rob_param: RTL

Parametrised reorder buffer, the successor to the fixed 2-wide ROB.
- Configurable depth, dispatch width, commit width and number of writeback ports.
- Owns both head (commit) and tail (allocate) pointers and an occupancy counter, so dispatch stall is generated here rather than externally.
- Adds full-pipeline flush.
- Sits between dispatch (allocation), the execution-finish buses (completion) and commit (ARF update, store release, branch predictor update).

---
 rtl/rob_param.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer.
//
// Owns the head (commit) pointer, the tail (allocate) pointer and the
// occupancy count. Dispatch writes up to DP_WIDTH entries per cycle at
// tail+k and reports the allocated tags. The finish buses set per-entry
// finish bits, and the branch bus also records the resolved target.
// Commit retires up to COM_WIDTH finished entries in order from head.
// A store or branch always closes the commit group, so at most one
// store/branch retires per cycle. i_flush discards every entry.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_flush             discard all entries; dispatch ignored, commit masked
//   i_dp_*              dispatch lanes (valid contiguous from lane 0)
//   o_dp_ptr, o_stall   allocated tag per lane, fewer than DP_WIDTH free
//   i_wb_vld/i_wb_tag   non-branch finish ports
//   i_br_*              branch finish with resolved target/direction
//   o_com_*             commit lanes plus st/br side information
//   o_count, o_empty    occupancy
//
// Optional feature (macro ROB_EXCP_EN): adds i_wb_excp, o_com_excp and
// o_com_excp_pc. An excepting entry retires alone in lane 0, with its
// rd write suppressed.
module rob_param #(
    parameter int ENT_NUM   = 64,
    parameter int ENT_SEL   = 6,
    parameter int DP_WIDTH  = 2,
    parameter int COM_WIDTH = 2,
    parameter int WB_PORTS  = 4,
    parameter int ARF_SEL   = 5,
    parameter int PC_WIDTH  = 32,
    parameter int GHR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic [DP_WIDTH-1:0]            i_dp_vld,
    input  logic [DP_WIDTH-1:0]            i_dp_rd_wr_en,
    input  logic [DP_WIDTH*ARF_SEL-1:0]    i_dp_rd_wr_addr,
    input  logic [DP_WIDTH-1:0]            i_dp_is_st,
    input  logic [DP_WIDTH-1:0]            i_dp_is_br,
    input  logic [DP_WIDTH*PC_WIDTH-1:0]   i_dp_pc,
    input  logic [DP_WIDTH*GHR_WIDTH-1:0]  i_dp_ghr,
    output logic [DP_WIDTH*ENT_SEL-1:0]    o_dp_ptr,
    output logic                           o_stall,
    input  logic [WB_PORTS-1:0]            i_wb_vld,
    input  logic [WB_PORTS*ENT_SEL-1:0]    i_wb_tag,
    input  logic                           i_br_vld,
    input  logic [ENT_SEL-1:0]             i_br_tag,
    input  logic [PC_WIDTH-1:0]            i_br_jmpaddr,
    input  logic                           i_br_jmpcond,
    output logic [COM_WIDTH-1:0]           o_com_vld,
    output logic [COM_WIDTH*ENT_SEL-1:0]   o_com_ptr,
    output logic [COM_WIDTH-1:0]           o_com_rd_wr_en,
    output logic [COM_WIDTH*ARF_SEL-1:0]   o_com_rd_wr_addr,
    output logic [$clog2(COM_WIDTH):0]     o_com_num,
    output logic                           o_com_st,
    output logic                           o_com_br,
    output logic [PC_WIDTH-1:0]            o_com_pc,
    output logic [GHR_WIDTH-1:0]           o_com_ghr,
    output logic [PC_WIDTH-1:0]            o_com_jmpaddr,
    output logic                           o_com_jmpcond,
`ifdef ROB_EXCP_EN
    input  logic [WB_PORTS-1:0]            i_wb_excp,
    output logic                           o_com_excp,
    output logic [PC_WIDTH-1:0]            o_com_excp_pc,
`endif
    output logic [ENT_SEL:0]               o_count,
    output logic                           o_empty
);

    localparam int CN_W = $clog2(COM_WIDTH) + 1;
    localparam logic [ENT_SEL:0] ENT_NUM_C  = (ENT_SEL+1)'(ENT_NUM);
    localparam logic [ENT_SEL:0] DP_WIDTH_C = (ENT_SEL+1)'(DP_WIDTH);

    // Control state (reset)
    logic [ENT_SEL-1:0] head_q, head_d;
    logic [ENT_SEL-1:0] tail_q, tail_d;
    logic [ENT_SEL:0]   count_q, count_d;
    logic [ENT_NUM-1:0] fin_q, fin_d;
`ifdef ROB_EXCP_EN
    logic [ENT_NUM-1:0] excp_q, excp_d;
`endif

    // Entry payload (not reset; always written at dispatch before use)
    logic [ENT_NUM-1:0]   ent_st_q, ent_br_q, ent_rd_en_q, ent_jmpcond_q;
    logic [ARF_SEL-1:0]   ent_rd_addr_q [ENT_NUM];
    logic [PC_WIDTH-1:0]  ent_pc_q      [ENT_NUM];
    logic [PC_WIDTH-1:0]  ent_jmpaddr_q [ENT_NUM];
    logic [GHR_WIDTH-1:0] ent_ghr_q     [ENT_NUM];

    logic               dp_acc;
    logic [ENT_SEL:0]   dp_num;
    logic [DP_WIDTH-1:0] dp_we;
    logic [ENT_SEL-1:0] dp_idx  [DP_WIDTH];
    logic [ENT_SEL-1:0] com_idx [COM_WIDTH];
    logic [COM_WIDTH-1:0] com_vld;
    logic [CN_W-1:0]    com_num;
    logic [ENT_SEL-1:0] sel_idx;

    assign o_stall = (ENT_NUM_C - count_q) < DP_WIDTH_C;
    assign o_count = count_q;
    assign o_empty = (count_q == '0);

    // Dispatch: lane k allocates tail+k when the whole group is accepted.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no path leaves it holding a value (latch).
        dp_acc   = !o_stall && !i_flush;
        dp_num   = '0;
        dp_we    = '0;
        o_dp_ptr = '0;
        for (int k = 0; k < DP_WIDTH; k++) begin
            dp_idx[k] = tail_q + ENT_SEL'(k);
            dp_we[k]  = dp_acc && i_dp_vld[k];
            dp_num    = dp_num + (ENT_SEL+1)'(dp_we[k]);
            o_dp_ptr[k*ENT_SEL +: ENT_SEL] = dp_idx[k];
        end
    end

    // Commit: in-order run of finished entries from head. A store/branch
    // (or an excepting entry) terminates the run after itself.
    always_comb begin
        com_vld          = '0;
        com_num          = '0;
        sel_idx          = head_q;
        o_com_st         = 1'b0;
        o_com_br         = 1'b0;
        o_com_ptr        = '0;
        o_com_rd_wr_en   = '0;
        o_com_rd_wr_addr = '0;
        for (int k = 0; k < COM_WIDTH; k++) begin
            com_idx[k] = head_q + ENT_SEL'(k);
        end
        com_vld[0] = (count_q != '0) && fin_q[com_idx[0]] && !i_flush;
        for (int k = 1; k < COM_WIDTH; k++) begin
            com_vld[k] = com_vld[k-1]
                       && !ent_st_q[com_idx[k-1]] && !ent_br_q[com_idx[k-1]]
`ifdef ROB_EXCP_EN
                       && !excp_q[com_idx[k-1]] && !excp_q[com_idx[k]]
`endif
                       && (count_q > (ENT_SEL+1)'(k)) && fin_q[com_idx[k]];
        end
        for (int k = 0; k < COM_WIDTH; k++) begin
            o_com_ptr[k*ENT_SEL +: ENT_SEL]        = com_idx[k];
            o_com_rd_wr_addr[k*ARF_SEL +: ARF_SEL] = ent_rd_addr_q[com_idx[k]];
            o_com_rd_wr_en[k] = com_vld[k] && ent_rd_en_q[com_idx[k]]
`ifdef ROB_EXCP_EN
                              && !excp_q[com_idx[k]]
`endif
                              ;
            if (com_vld[k]) begin
                com_num = com_num + CN_W'(1);
                if (ent_st_q[com_idx[k]] || ent_br_q[com_idx[k]]) begin
                    sel_idx  = com_idx[k];
                    o_com_st = ent_st_q[com_idx[k]];
                    o_com_br = ent_br_q[com_idx[k]];
                end
            end
        end
    end

    assign o_com_vld     = com_vld;
    assign o_com_num     = com_num;
    assign o_com_pc      = ent_pc_q[sel_idx];
    assign o_com_ghr     = ent_ghr_q[sel_idx];
    assign o_com_jmpaddr = ent_jmpaddr_q[sel_idx];
    assign o_com_jmpcond = ent_jmpcond_q[sel_idx];
`ifdef ROB_EXCP_EN
    assign o_com_excp    = com_vld[0] && excp_q[head_q];
    assign o_com_excp_pc = ent_pc_q[head_q];
`endif

    // Next control state. Flush overrides dispatch, commit and finish.
    always_comb begin
        head_d  = head_q + ENT_SEL'(com_num);
        tail_d  = tail_q + ENT_SEL'(dp_num);
        count_d = count_q + dp_num - (ENT_SEL+1)'(com_num);
        fin_d   = fin_q;
`ifdef ROB_EXCP_EN
        excp_d  = excp_q;
`endif
        for (int k = 0; k < DP_WIDTH; k++) begin
            if (dp_we[k]) begin
                fin_d[dp_idx[k]] = 1'b0;
`ifdef ROB_EXCP_EN
                excp_d[dp_idx[k]] = 1'b0;
`endif
            end
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (i_wb_vld[p]) begin
                fin_d[i_wb_tag[p*ENT_SEL +: ENT_SEL]] = 1'b1;
`ifdef ROB_EXCP_EN
                if (i_wb_excp[p]) excp_d[i_wb_tag[p*ENT_SEL +: ENT_SEL]] = 1'b1;
`endif
            end
        end
        if (i_br_vld) fin_d[i_br_tag] = 1'b1;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fin_d   = '0;
`ifdef ROB_EXCP_EN
            excp_d  = '0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fin_q   <= '0;
`ifdef ROB_EXCP_EN
            excp_q  <= '0;
`endif
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fin_q   <= fin_d;
`ifdef ROB_EXCP_EN
            excp_q  <= excp_d;
`endif
        end
    end

    // NOTE: payload storage has no reset; an entry is only read once its
    // finish bit is set, which requires a prior dispatch write, so a reset
    // here would only add fan-out and block RAM mapping.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DP_WIDTH; k++) begin
            if (dp_we[k]) begin
                ent_st_q[dp_idx[k]]      <= i_dp_is_st[k];
                ent_br_q[dp_idx[k]]      <= i_dp_is_br[k];
                ent_rd_en_q[dp_idx[k]]   <= i_dp_rd_wr_en[k];
                ent_rd_addr_q[dp_idx[k]] <= i_dp_rd_wr_addr[k*ARF_SEL +: ARF_SEL];
                ent_pc_q[dp_idx[k]]      <= i_dp_pc[k*PC_WIDTH +: PC_WIDTH];
                ent_ghr_q[dp_idx[k]]     <= i_dp_ghr[k*GHR_WIDTH +: GHR_WIDTH];
            end
        end
        if (i_br_vld && !i_flush) begin
            ent_jmpaddr_q[i_br_tag] <= i_br_jmpaddr;
            ent_jmpcond_q[i_br_tag] <= i_br_jmpcond;
        end
    end

endmodule
